acia_tx_fifo: RTL and testbench

Buffered asynchronous serial transmitter, 8N1 framing, LSB first. It accepts bytes from a CPU-side write strobe into an internal FIFO and serialises them back-to-back onto tx_serial. It is the transmit-side counterpart to the ACIA's receive path. It drops into the ACIA in place of the unbuffered transmitter so the 6502 can queue output without polling txe per byte.

---
 rtl/acia_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/acia_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_acia_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// ============================================================================
// Module   : acia_pkg
// Purpose  : Shared ACIA constants, transmit state type and baud helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acia_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic int sym_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO with registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guarded against the registered flags so a pop never frees a slot for a same-cycle push.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == LW'(DEPTH));
  assign empty = (r_count == '0);
  assign level = r_count;

endmodule

`default_nettype wire

// File: rtl/acia_tx_fifo.sv
// ============================================================================
// Module   : acia_tx_fifo
// Purpose  : Buffered 8N1 serial transmitter, LSB first, back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acia_tx_fifo
  import acia_pkg::*;
#(
  parameter  int CLK_FREQ   = 12000000,
  parameter  int BAUD       = 9600,
  parameter  int FIFO_DEPTH = 16,
  localparam int SYM_CNT    = sym_cnt(CLK_FREQ, BAUD),
  localparam int SCW        = $clog2(SYM_CNT),
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_dat,
  input  logic          tx_stb,
  input  logic          ovf_clr,
  output logic          tx_serial,
  output logic          tx_busy,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          ovf
);

  localparam int             BIW         = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] c_tmr_load  = SCW'(SYM_CNT - 1);
  localparam logic [BIW-1:0] c_last_bit  = BIW'(DATA_BITS - 1);

  tx_state_t            r_state,   w_state_nxt;
  logic [SCW-1:0]       r_timer,   w_timer_nxt;
  logic [BIW-1:0]       r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
  logic                 r_tx_serial;
  logic                 r_ovf;
  logic                 w_line;
  logic                 w_pop;
  logic                 w_tmr_zero;
  logic [7:0]           w_fifo_dout;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_stb),
    .pop   (w_pop),
    .din   (tx_dat),
    .dout  (w_fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx_serial <= STOP_LVL;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_tx_serial <= w_line;
      // A dropped write outranks a same-cycle clear.
      if (tx_stb && full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign w_tmr_zero = (r_timer == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_line        = STOP_LVL;
    case (r_state)
      IDLE: begin
        w_line = STOP_LVL;
        if (!empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_timer_nxt = c_tmr_load;
          w_state_nxt = START;
        end
      end
      START: begin
        w_line = START_LVL;
        if (w_tmr_zero) begin
          w_timer_nxt   = c_tmr_load;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end else begin
          w_timer_nxt = r_timer - SCW'(1);
        end
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_tmr_zero) begin
          w_timer_nxt = c_tmr_load;
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == c_last_bit) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIW'(1);
          end
        end else begin
          w_timer_nxt = r_timer - SCW'(1);
        end
      end
      STOP: begin
        w_line = STOP_LVL;
        if (w_tmr_zero) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_timer_nxt = c_tmr_load;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - SCW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign tx_serial = r_tx_serial;
  assign tx_busy   = (r_state != IDLE);
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_acia_tx_fifo.sv
// ============================================================================
// Module   : tb_acia_tx_fifo
// Purpose  : Scoreboarded bench: frame-level model vs. UART-style line decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acia_tx_fifo;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DEPTH    = 4;
  localparam int SYM      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * SYM;
  localparam int LW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_dat = 8'h00;
  logic          tx_stb = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx_serial;
  logic          tx_busy;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          ovf;

  acia_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_dat    (tx_dat),
    .tx_stb    (tx_stb),
    .ovf_clr   (ovf_clr),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  int         m_level = 0;
  int         m_rem   = 0;
  logic       m_ovf   = 1'b0;
  logic       m_pop;
  logic       m_acc;

  // Model: a byte leaves the queue when the line is free (or its last stop clock
  // is running) and occupies the line for exactly one frame time.
  always_comb begin
    m_pop = (m_level > 0) && (m_rem <= 1);
    m_acc = tx_stb && (m_level < DEPTH);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level <= 0;
      m_rem   <= 0;
      m_ovf   <= 1'b0;
      m_q.delete();
      exp_q.delete();
    end else begin
      if (m_pop) begin
        exp_q.push_back(exp_t'{m_q[0], cyc + 2});
        m_q.pop_front();
        m_rem <= FRAME;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
      if (m_acc) m_q.push_back(tx_dat);
      m_level <= m_level + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
      if (tx_stb && (m_level == DEPTH)) m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: status outputs every cycle, line decoded mid-bit like a receiver.
  initial begin
    bit         in_frame;
    int         pos;
    logic [7:0] got;
    in_frame = 1'b0;
    pos      = 0;
    got      = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        continue;
      end
      check("level", level, m_level);
      check("full", full, m_level == DEPTH);
      check("empty", empty, m_level == 0);
      check("tx_busy", tx_busy, m_rem > 0);
      check("ovf", ovf, m_ovf);
      if (!in_frame) begin
        if (tx_serial == 1'b0) begin
          in_frame = 1'b1;
          pos      = 0;
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("start_cycle", cyc, exp_q[0].start);
        end
      end else begin
        pos++;
        if (pos == SYM / 2) begin
          check("start_bit", tx_serial, 1'b0);
        end else if (pos >= SYM + SYM / 2 && pos < 9 * SYM && (pos - SYM / 2) % SYM == 0) begin
          got[(pos - SYM / 2) / SYM - 1] = tx_serial;
        end else if (pos == 9 * SYM + SYM / 2) begin
          check("stop_bit", tx_serial, 1'b1);
          if (exp_q.size() > 0) begin
            check("data_byte", got, exp_q[0].b);
            exp_q.pop_front();
          end
        end
        if (pos == FRAME - 1) in_frame = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] b);
    tx_stb = 1'b1;
    tx_dat = b;
    @(posedge clk);
    #1;
    tx_stb  = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_rem != 0 || m_level != 0) && k < 3 * DEPTH * FRAME) begin
      idle(1);
      k++;
    end
    check("drain", (exp_q.size() == 0) && (m_rem == 0) && (m_level == 0), 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] base;
    int         sent;
    int         k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_serial", tx_serial, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    idle(2);

    // Single byte, then three back-to-back.
    write(8'hA5);
    idle(FRAME + 40);
    write(8'h00);
    write(8'hFF);
    write(8'h55);
    wait_drain();

    // Burst into an idle transmitter: five accepted, sixth dropped.
    repeat (6) write(8'($urandom));
    check("burst_full", full, 1'b1);
    check("burst_level", level, DEPTH);
    check("burst_ovf", ovf, 1'b1);
    ovf_clr = 1'b1;
    write(8'($urandom));
    check("set_beats_clr", ovf, 1'b1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);

    // Write while full on the cycle of a stop-to-start pop.
    k = 0;
    while (m_rem != 1 && k < 2 * FRAME) begin
      idle(1);
      k++;
    end
    check("reach_stop_end", m_rem, 1);
    write(8'($urandom));
    check("pop_drop_level", level, DEPTH - 1);
    check("pop_drop_ovf", ovf, 1'b1);
    check("pop_drop_full", full, 1'b0);
    wait_drain();
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    // Asynchronous reset in the middle of a data bit.
    write(8'h3C);
    write(8'($urandom));
    write(8'($urandom));
    idle(3 * SYM + 5);
    #3;
    rst = 1'b1;
    #1;
    check("arst_tx_serial", tx_serial, 1'b1);
    check("arst_tx_busy", tx_busy, 1'b0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1'b1);
    idle(2);
    rst = 1'b0;
    idle(FRAME + 100);

    // Continuous incrementing stream across two pointer wraps.
    base = 8'($urandom);
    sent = 0;
    k    = 0;
    while (sent < 2 * DEPTH && k < 4 * DEPTH * FRAME) begin
      if (m_level < DEPTH) begin
        write(base + 8'(sent));
        sent++;
      end else begin
        idle(1);
      end
      k++;
    end
    check("stream_sent", sent, 2 * DEPTH);
    wait_drain();

    // Random traffic with occasional overflow clears.
    for (int i = 0; i < 800; i++) begin
      tx_stb  = ($urandom_range(0, 7) == 0);
      tx_dat  = 8'($urandom);
      ovf_clr = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    tx_stb  = 1'b0;
    ovf_clr = 1'b0;
    wait_drain();
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
